// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b1;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_rx_buf.sv
// One-entry valid/ready output buffer with sticky overrun for the frame receiver.
module serial_rx_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] word,
  input  logic              perr,
  input  logic              data_ready,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              overrun
);

  logic accept_c;
  logic drop_c;

  // A completed frame fits if the slot is empty or is being drained this cycle.
  assign accept_c = done && (!data_valid || data_ready);
  assign drop_c   = done && data_valid && !data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else if (accept_c) begin
      data_out   <= word;
      parity_err <= perr;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Set wins over a coincident clear so a drop is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop_c) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start-bit detect, MSB-first data capture, optional even parity.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              bit_en,
  input  logic              data_ready,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_c;
  logic [DATA_W-1:0] word_c;
  logic              perr_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, shift/count and frame-completion decode; all gated by bit_en.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_c  = 1'b0;
    word_c  = sr_q;
    perr_c  = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (serial_in == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          sr_d  = {sr_q[DATA_W-2:0], serial_in};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              state_d = IDLE;
              done_c  = 1'b1;
              word_c  = sr_d;
            end
          end
        end
        PARITY: begin
          state_d = IDLE;
          done_c  = 1'b1;
          perr_c  = serial_in ^ parity(PAR_MAX_W'(sr_q));
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  serial_rx_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .done       (done_c),
    .word       (word_c),
    .perr       (perr_c),
    .data_ready (data_ready),
    .ovr_clr    (ovr_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

endmodule
